// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   ILEN             : instruction word width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP              : canonical no-op encoding (addi x0, x0, 0)
package fetch_pkg;

  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO holding fetched {instr, pc} pairs.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   flush       : discards all entries; wins over push and pop
//   push        : write push_data at the tail
//   push_data   : entry to write
//   pop         : advance the head (caller guarantees count != 0)
//   head_data   : entry at the head (meaningful only when count != 0)
//   count       : number of valid entries, 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;

  // DEPTH is a power of two, so the pointers wrap at DEPTH naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Storage is left unreset; count gates whether the head is meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end with a credit-limited prefetch buffer.
// Issues sequential word-aligned fetches, buffers in-order responses with
// their PCs, hands them to decode, and squashes everything in flight on a
// redirect.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   imem_req_valid/ready/addr      : fetch request handshake and address
//   imem_rsp_valid/data            : in-order response, no backpressure
//   redirect_valid/redirect_pc     : single-cycle control-flow redirect
//   dec_valid/ready, dec_instr/pc  : instruction handoff to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [ILEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ILEN + XLEN;

  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]   outstanding_reg, outstanding_next;
  logic [CW-1:0]   discard_reg, discard_next;
  logic [CW-1:0]   count;
  logic [CW:0]     credits_used;
  logic            req_fire, push, pop;
  logic [XLEN-1:0] redirect_target;
  logic [EW-1:0]   head_data;

  // PCs of accepted requests, consumed in order as responses return.
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [PW-1:0]   pc_wr_reg, pc_rd_reg;
  logic [XLEN-1:0] rsp_pc;

  // Buffered plus in-flight never exceeds DEPTH, so the buffer cannot overflow.
  assign credits_used   = {1'b0, count} + {1'b0, outstanding_reg};
  assign imem_req_valid = !reset && (credits_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign rsp_pc          = pc_mem[pc_rd_reg];

  // A response is stale if it lands in a redirect cycle or is still owed
  // to a pre-redirect request.
  assign push = imem_rsp_valid && !redirect_valid && (discard_reg == '0);

  assign dec_valid = (count != '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign dec_instr = (count != '0) ? head_data[EW-1:XLEN] : '0;
  assign dec_pc    = (count != '0) ? head_data[XLEN-1:0]  : '0;

  assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    discard_next  = discard_reg;
    if (redirect_valid) begin
      // Every request still in flight, including one firing now, is stale.
      fetch_pc_next = redirect_target;
      discard_next  = outstanding_next;
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + XLEN'(4);
      if (imem_rsp_valid && (discard_reg != '0)) discard_next = discard_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      pc_wr_reg       <= '0;
      pc_rd_reg       <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      if (req_fire)       pc_wr_reg <= pc_wr_reg + PW'(1);
      if (imem_rsp_valid) pc_rd_reg <= pc_rd_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pc_mem[pc_wr_reg] <= fetch_pc_reg;
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model,
// an independent fetch-address model, and a decode scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] data; int due; } mem_t;
  typedef struct { int lat; logic [31:0] rpc; logic [31:0] want; } redir_vec_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;
  int n_fires = 0;

  logic        drv_reset = 1'b1;
  logic        drv_ready = 1'b1;
  logic        drv_redir = 1'b0;
  logic        drv_dec_ready = 1'b1;
  logic [31:0] drv_rpc = '0;
  logic [31:0] exp_addr = RST_PC;
  logic        fired = 1'b0;
  logic        popped = 1'b0;
  logic [31:0] fire_addr = '0;
  logic [31:0] pop_pc = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ NOP;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 time unit later.
  task automatic tick();
    int due;
    exp_t e;
    @(negedge clk);
    cyc++;
    reset          = drv_reset;
    imem_req_ready = drv_ready;
    redirect_valid = drv_redir;
    redirect_pc    = drv_rpc;
    dec_ready      = drv_dec_ready;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (drv_reset) begin
      mem_q.delete();
      last_due = 0;
    end else if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    #1;
    fired  = 1'b0;
    popped = 1'b0;
    if (drv_reset) begin
      chk("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
      exp_q.delete();
      exp_addr = RST_PC;
    end else begin
      if (drv_redir) chk("dec_valid_in_redirect", {31'b0, dec_valid}, 32'd0);
      if (dec_valid && dec_ready) begin
        popped = 1'b1;
        pop_pc = dec_pc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dec_unexpected: got pc %h, want no instruction (cycle %0d)", dec_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("dec pc=%h instr=%h (cycle %0d)", dec_pc, dec_instr, cyc);
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_instr", dec_instr, e.instr);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        fired     = 1'b1;
        fire_addr = imem_req_addr;
        n_fires++;
        chk("req_addr", imem_req_addr, exp_addr);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{data: instr_of(exp_addr), due: due});
        if (!drv_redir) exp_q.push_back('{pc: exp_addr, instr: instr_of(exp_addr)});
        exp_addr += 32'd4;
      end
      if (drv_redir) begin
        exp_q.delete();
        exp_addr = drv_rpc & 32'hFFFF_FFFC;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fire(input string name, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (fired) ok = 1'b1;
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_pop(input string name, input int budget, output int n);
    logic ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      n++;
      if (popped) ok = 1'b1;
    end
    if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    drv_reset = 1'b1;
    drv_redir = 1'b0;
    ticks(2);
    drv_reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    drv_redir = 1'b1;
    drv_rpc   = target;
    tick();
    drv_redir = 1'b0;
  endtask

  initial begin #400000; $display("FAIL watchdog: got no finish, want finish"); $fatal(1); end

  initial begin : main
    redir_vec_t vt [5];
    int n;
    vt[0] = '{lat: 3, rpc: 32'h0000_0100, want: 32'h0000_0100};
    vt[1] = '{lat: 1, rpc: 32'h0000_0203, want: 32'h0000_0200};
    vt[2] = '{lat: 2, rpc: 32'hFFFF_FFFE, want: 32'hFFFF_FFFC};
    vt[3] = '{lat: 1, rpc: 32'h0000_0041, want: 32'h0000_0040};
    vt[4] = '{lat: 4, rpc: 32'h8000_0007, want: 32'h8000_0004};

    // Reset state and first-instruction latency (fire T, rsp T+1, dec T+2).
    do_reset();
    tick();
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_req_fired", {31'b0, fired}, 32'd1);
    wait_pop("first_dec", 20, n);
    chk("first_dec_latency", 32'(n), 32'd2);
    chk("first_dec_pc", pop_pc, RST_PC);
    ticks(10);

    // Decode stalled: credits stop issue at DEPTH, then drain in order.
    do_reset();
    drv_dec_ready = 1'b0;
    n_fires = 0;
    ticks(20);
    chk("stall_fires", 32'(n_fires), 32'(DEPTH));
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_dec_valid", {31'b0, dec_valid}, 32'd1);
    chk("stall_head_pc", dec_pc, RST_PC);
    drv_dec_ready = 1'b1;
    ticks(20);
    drv_ready = 1'b0;
    ticks(10);
    chk("stall_drain_left", 32'(exp_q.size()), 32'd0);
    chk("stall_drain_dec_valid", {31'b0, dec_valid}, 32'd0);
    drv_ready = 1'b1;

    // Redirect vectors: aligned target is the next fetch and the next decode.
    foreach (vt[i]) begin
      lat = vt[i].lat;
      ticks(8);
      $display("vector %0d: lat=%0d redirect_pc=%h inflight=%0d", i, lat, vt[i].rpc, mem_q.size());
      redirect(vt[i].rpc);
      wait_fire("redir_fire", 20);
      chk("redir_addr", fire_addr, vt[i].want);
      wait_pop("redir_dec", 30, n);
      chk("redir_dec_pc", pop_pc, vt[i].want);
    end

    // Fetch address wraps to zero past the top of the address space.
    lat = 1;
    redirect(32'hFFFF_FFFC);
    wait_fire("wrap_fire0", 20);
    chk("wrap_addr0", fire_addr, 32'hFFFF_FFFC);
    wait_fire("wrap_fire1", 20);
    chk("wrap_addr1", fire_addr, 32'h0000_0000);
    ticks(6);

    // Back-to-back redirects: the later one wins.
    lat = 2;
    ticks(4);
    drv_redir = 1'b1;
    drv_rpc = 32'h0000_0300;
    tick();
    drv_rpc = 32'h0000_0400;
    tick();
    drv_redir = 1'b0;
    wait_pop("b2b_dec", 30, n);
    chk("b2b_dec_pc", pop_pc, 32'h0000_0400);

    // Reset with entries buffered and two requests in flight.
    do_reset();
    lat = 3;
    drv_dec_ready = 1'b0;
    ticks(5);
    chk("pre_reset_inflight", 32'(mem_q.size()), 32'd2);
    chk("pre_reset_dec_valid", {31'b0, dec_valid}, 32'd1);
    do_reset();
    drv_dec_ready = 1'b1;
    tick();
    chk("post_reset_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("post_reset_req_addr", imem_req_addr, RST_PC);
    wait_pop("post_reset_dec", 20, n);
    chk("post_reset_dec_pc", pop_pc, RST_PC);

    // Random traffic with backpressure and occasional redirects.
    for (int blk = 0; blk < 4; blk++) begin
      lat = 1 + int'($urandom_range(0, 3));
      for (int i = 0; i < 50; i++) begin
        drv_ready     = ($urandom_range(0, 3) != 0);
        drv_dec_ready = ($urandom_range(0, 2) != 0);
        drv_redir     = ($urandom_range(0, 15) == 0);
        drv_rpc       = $urandom;
        tick();
      end
    end
    drv_redir = 1'b0;
    drv_ready = 1'b0;
    drv_dec_ready = 1'b1;
    ticks(15);
    chk("rand_drain_left", 32'(exp_q.size()), 32'd0);
    chk("rand_drain_dec_valid", {31'b0, dec_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
